// File: rtl/ram_arb_pkg.sv
// Shared types and width defaults for the RAM arbiter (ram_arbiter, ram_arb_select).
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned DATA_W_DEF = 64;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} arb_state_t;
    typedef enum logic {OWNER_F, OWNER_D} owner_t;

endpackage

// File: rtl/ram_arb_select.sv
// Combinational winner selection between fetch and data requesters.
// Define RAM_ARB_ROUND_ROBIN_EN to alternate on simultaneous requests; default is D over F.
module ram_arb_select
    import ram_arb_pkg::*;
(
    input  logic   i_f_valid,
    input  logic   i_d_valid,
    input  owner_t i_last_grant,
    output logic   o_grant_f,
    output logic   o_grant_d
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_grant_f = 1'b0;
        o_grant_d = 1'b0;
        if (i_f_valid && i_d_valid) begin
            // Contention goes to whoever did not win last time
            if (i_last_grant == OWNER_D) begin
                o_grant_f = 1'b1;
            end else begin
                o_grant_d = 1'b1;
            end
        end else begin
            o_grant_f = i_f_valid;
            o_grant_d = i_d_valid;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = (i_last_grant == OWNER_D);

    always_comb begin
        o_grant_d = i_d_valid;
        o_grant_f = i_f_valid && !i_d_valid;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: serialises fetch (F) and load/store (D) through IDLE/ACCESS/RESPOND.
// Optional RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration in ram_arb_select.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_address,
    output logic              f_ready,
    output logic              f_resp_valid,
    output logic [DATA_W-1:0] f_read_data,
    input  logic              d_valid,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_write_data,
    output logic              d_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_read_data,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] write_data,
    output logic              memory_write,
    output logic              memory_read,
    input  logic [DATA_W-1:0] read_data
);

    arb_state_t        r_state;
    owner_t            r_owner;
    owner_t            r_last_grant;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_f_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_grant_f;
    logic w_grant_d;
    logic w_idle;
    logic w_access;
    logic w_respond;

    ram_arb_select u_select (
        .i_f_valid    (f_valid),
        .i_d_valid    (d_valid),
        .i_last_grant (r_last_grant),
        .o_grant_f    (w_grant_f),
        .o_grant_d    (w_grant_d)
    );

    // All externally visible strobes are masked by reset so nothing leaks in the reset cycle
    assign w_idle    = (r_state == IDLE) && !reset;
    assign w_access  = (r_state == ACCESS) && !reset;
    assign w_respond = (r_state == RESPOND) && !reset;

    assign f_ready        = w_idle && w_grant_f;
    assign d_ready        = w_idle && w_grant_d;
    assign memory_address = r_addr;
    assign write_data     = r_wdata;
    assign memory_write   = w_access && r_write;
    assign memory_read    = w_access && !r_write;
    assign f_resp_valid   = w_respond && (r_owner == OWNER_F);
    assign d_resp_valid   = w_respond && (r_owner == OWNER_D);
    assign f_read_data    = r_f_rdata;
    assign d_read_data    = r_d_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_F;
            r_last_grant <= OWNER_F;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (d_ready) begin
                        r_owner      <= OWNER_D;
                        r_last_grant <= OWNER_D;
                        r_write      <= d_write;
                        r_addr       <= d_address;
                        r_wdata      <= d_write_data;
                        r_state      <= ACCESS;
                    end else if (f_ready) begin
                        r_owner      <= OWNER_F;
                        r_last_grant <= OWNER_F;
                        r_write      <= 1'b0;
                        r_addr       <= f_address;
                        r_wdata      <= '0;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Only D can write; a store acknowledge returns zero data
                    if (r_write) begin
                        r_d_rdata <= '0;
                    end else if (r_owner == OWNER_F) begin
                        r_f_rdata <= read_data;
                    end else begin
                        r_d_rdata <= read_data;
                    end
                    r_state <= RESPOND;
                end
                RESPOND: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small behavioural RAM model.
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_valid;
    logic [63:0] f_address;
    logic        f_ready;
    logic        f_resp_valid;
    logic [63:0] f_read_data;
    logic        d_valid;
    logic        d_write;
    logic [63:0] d_address;
    logic [63:0] d_write_data;
    logic        d_ready;
    logic        d_resp_valid;
    logic [63:0] d_read_data;
    logic [63:0] memory_address;
    logic [63:0] write_data;
    logic        memory_write;
    logic        memory_read;
    logic [63:0] read_data;

    logic [63:0] mem [0:7];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    assign read_data = mem[memory_address[5:3]];

    always @(posedge clock) begin
        if (memory_write) mem[memory_address[5:3]] <= write_data;
    end

    ram_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .f_valid        (f_valid),
        .f_address      (f_address),
        .f_ready        (f_ready),
        .f_resp_valid   (f_resp_valid),
        .f_read_data    (f_read_data),
        .d_valid        (d_valid),
        .d_write        (d_write),
        .d_address      (d_address),
        .d_write_data   (d_write_data),
        .d_ready        (d_ready),
        .d_resp_valid   (d_resp_valid),
        .d_read_data    (d_read_data),
        .memory_address (memory_address),
        .write_data     (write_data),
        .memory_write   (memory_write),
        .memory_read    (memory_read),
        .read_data      (read_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full request: present at T, ACCESS at T+1, response at T+2, returns in IDLE at T+3.
    task automatic do_req(input bit is_d, input bit is_w, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_rd, input string tag);
        if (is_d) begin
            d_valid      = 1'b1;
            d_write      = is_w;
            d_address    = addr;
            d_write_data = wdata;
        end else begin
            f_valid   = 1'b1;
            f_address = addr;
        end
        @(negedge clock);
        check({tag, " ready"}, is_d ? d_ready : f_ready, 64'd1);
        check({tag, " other ready"}, is_d ? f_ready : d_ready, 64'd0);
        @(posedge clock);
        #1;
        d_valid = 1'b0;
        f_valid = 1'b0;
        @(negedge clock);
        check({tag, " mem_read"}, memory_read, is_w ? 64'd0 : 64'd1);
        check({tag, " mem_write"}, memory_write, is_w ? 64'd1 : 64'd0);
        check({tag, " mem_addr"}, memory_address, addr);
        if (is_w) check({tag, " wdata"}, write_data, wdata);
        @(negedge clock);
        check({tag, " resp"}, is_d ? d_resp_valid : f_resp_valid, 64'd1);
        check({tag, " other resp"}, is_d ? f_resp_valid : d_resp_valid, 64'd0);
        check({tag, " rdata"}, is_d ? d_read_data : f_read_data, exp_rd);
        check({tag, " mem_write after"}, memory_write, 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit exp_d;
        bit exp_f;
        for (int i = 0; i < 8; i++) mem[i] = 64'h0;
        mem[0]       = 64'd12;
        mem[1]       = 64'hA5A5;
        reset        = 1'b1;
        f_valid      = 1'b0;
        f_address    = '0;
        d_valid      = 1'b1;
        d_write      = 1'b0;
        d_address    = '0;
        d_write_data = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst d_ready", d_ready, 64'd0);
        check("rst f_ready", f_ready, 64'd0);
        check("rst mem_read", memory_read, 64'd0);
        check("rst mem_write", memory_write, 64'd0);
        check("rst mem_addr", memory_address, 64'd0);
        check("rst wdata", write_data, 64'd0);
        check("rst d_rdata", d_read_data, 64'd0);
        check("rst f_rdata", f_read_data, 64'd0);
        check("rst resp", {62'd0, f_resp_valid, d_resp_valid}, 64'd0);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        d_valid = 1'b0;

        do_req(1'b1, 1'b0, 64'd0, 64'd0, 64'd12, "load0");
        do_req(1'b1, 1'b1, 64'd16, 64'h1122334455667788, 64'd0, "store16");
        do_req(1'b1, 1'b0, 64'd16, 64'd0, 64'h1122334455667788, "load16");
        do_req(1'b0, 1'b0, 64'd0, 64'd0, 64'd12, "fetch0");
        check("fetch keeps d_rdata", d_read_data, 64'h1122334455667788);

        // Both requesters valid continuously; last grant so far was F
        d_valid   = 1'b1;
        d_write   = 1'b0;
        d_address = 64'd8;
        f_valid   = 1'b1;
        f_address = 64'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_d = (i % 6) == 0;
            exp_f = (i % 6) == 3;
`else
            exp_d = (i % 3) == 0;
            exp_f = 1'b0;
`endif
            check($sformatf("both d_ready c%0d", i), d_ready, {63'd0, exp_d});
            check($sformatf("both f_ready c%0d", i), f_ready, {63'd0, exp_f});
        end
        d_valid = 1'b0;
        f_valid = 1'b0;
        @(posedge clock);
        #1;

        // Store to 8 interrupted by reset during its ACCESS cycle
        d_valid      = 1'b1;
        d_write      = 1'b1;
        d_address    = 64'd8;
        d_write_data = 64'hFF;
        @(negedge clock);
        check("rststore d_ready", d_ready, 64'd1);
        @(posedge clock);
        #1;
        d_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clock);
        check("rststore mem_write", memory_write, 64'd0);
        check("rststore mem_read", memory_read, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rststore d_resp", d_resp_valid, 64'd0);
        check("rststore f_resp", f_resp_valid, 64'd0);
        check("rststore mem8", mem[1], 64'hA5A5);
        @(posedge clock);
        #1;
        do_req(1'b1, 1'b0, 64'd8, 64'd0, 64'hA5A5, "load8");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port byte-addressed 64-bit RAM between two requesters: instruction fetch (port F, read-only) and data load/store (port D).
- Sits between the CPU front end / load-store unit and the RAM, and is the only block driving RAM control inputs.
- Serialises accesses with a 3-state FSM, latches each request and registers the read response.

Parameters:
- ADDR_W, 64, request and RAM address width.
- DATA_W, 64, data width; must equal the RAM word width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- f_valid  in  1  fetch request valid.
- f_address  in  ADDR_W  fetch byte address.
- f_ready  out  1  fetch request accepted this cycle.
- f_resp_valid  out  1  fetch read data valid, one-cycle pulse.
- f_read_data  out  DATA_W  fetch read data.
- d_valid  in  1  data request valid.
- d_write  in  1  1 = store, 0 = load.
- d_address  in  ADDR_W  data byte address.
- d_write_data  in  DATA_W  store data.
- d_ready  out  1  data request accepted this cycle.
- d_resp_valid  out  1  load data or store acknowledge, one-cycle pulse.
- d_read_data  out  DATA_W  load data; 0 for a store acknowledge.
- memory_address  out  ADDR_W  to RAM.
- write_data  out  DATA_W  to RAM.
- memory_write  out  1  to RAM.
- memory_read  out  1  to RAM.
- read_data  in  DATA_W  from RAM; combinational read.

Behaviour:
- Reset values:
  - State is IDLE.
  - f_ready, d_ready, f_resp_valid, d_resp_valid, memory_write and memory_read are 0.
  - memory_address, write_data, f_read_data and d_read_data are 0.
  - last_grant is F.
- Requester handshake:
  - A requester holds valid and all request fields stable until ready is high.
  - A transfer occurs when valid and ready are both high on the same cycle.
  - Only one requester may be outstanding at a time.
- IDLE state:
  - ready is combinational and is high only for the arbitration winner, only while in IDLE and reset is low.
  - Fixed priority: D wins over F.
  - On a transfer, latch address, write data, the write bit and the owner ID, then go to ACCESS.
  - With no valid request, stay in IDLE.
- ACCESS state (exactly 1 cycle):
  - Drive memory_address and write_data from the latched request.
  - Assert memory_write for a store, or memory_read for a load or fetch, never both.
  - A store commits at the closing edge.
  - For a read, capture read_data at the closing edge into the owner's read-data register.
  - Go to RESPOND.
- RESPOND state (exactly 1 cycle):
  - The owner's resp_valid is high.
  - The read-data register holds its value until that owner's next response.
  - Go to IDLE.
- Timing:
  - Transfer at cycle T gives ACCESS at T+1 and resp_valid at T+2.
  - Next acceptance is possible at T+3, so throughput is one access per 3 cycles.
- Address and width rules:
  - The address passes through unmodified; no alignment check.
  - The RAM consumes the low bits of the address.
- memory_write and memory_read are gated by !reset, so reset asserted during ACCESS commits no write.
- Reset asserted in any state returns the block to IDLE next cycle and drops any pending response (no resp_valid).
- Both valid in IDLE: only the winner sees ready; the loser keeps valid and is considered again at the next IDLE.
- F is never written through this block; F requests with no data-path involvement are read-only by construction.

Optional Feature:
- RAM_ARB_ROUND_ROBIN_EN:
  - When defined, simultaneous requests are granted to the requester that is not last_grant.
  - last_grant updates on every transfer.
  - A single valid requester always wins.
- When not defined: fixed priority D over F, and last_grant is unused.

Decomposition:
- ram_arb_pkg contains:
  - typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} arb_state_t;
  - typedef enum logic {OWNER_F, OWNER_D} owner_t;
  - the ADDR_W and DATA_W defaults.
- Sub-module ram_arb_select: combinational winner selection from f_valid, d_valid and last_grant, containing the RR macro logic.
- The FSM and request/response registers live in ram_arbiter.

Test Plan:
- d_valid=1, d_write=0, d_address=0 after reset, with the RAM's memory[0]=12 and bytes 1..7 all 0 -> d_ready at T, memory_read at T+1, d_resp_valid at T+2 with d_read_data=64'd12.
- Store d_address=16, d_write_data=64'h1122334455667788, then load address 16 -> memory_write for exactly 1 cycle, then d_read_data=64'h1122334455667788.
- f_valid and d_valid both high continuously, fixed priority -> D granted every 3 cycles and f_ready never high; with RAM_ARB_ROUND_ROBIN_EN -> grants alternate D, F, D, F.
- Fetch from f_address=0 -> f_resp_valid at T+2 with f_read_data=12, and d_resp_valid stays 0.
- Reset pulsed during the ACCESS of a store to address 8 with data 64'hFF -> memory_write is 0 that cycle, address 8 is unchanged, no resp_valid, and the block is in IDLE next cycle.
